dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder that services the CPU datapath's load/store requests (`readCntrl_in` / `writeCntrl_in`, `address_in`, `writeData_in`) with a programmable wait-state latency and a one-cycle completion pulse. It sits on the memory side of the datapath's data-memory port and replaces the zero-latency data memory once the core is upgraded to stall on memory. It also reports illegal accesses: misaligned, out-of-range, or conflicting read and write.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two, at least 4.
- `LATENCY`, default 2: cycles from request sampled to `ready_out`; legal range 1..15.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `readCntrl_in`  in  1  load request.
- `writeCntrl_in`  in  1  store request.
- `address_in`  in  32  byte address.
- `writeData_in`  in  32  store data.
- `data_out`  out  32  load data; valid while `ready_out` is high.
- `ready_out`  out  1  one-cycle completion pulse.
- `error_out`  out  1  high with `ready_out` when the access was illegal.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - When `readCntrl_in | writeCntrl_in` is high, capture address, data, and kind.
  - Go to RESP if `LATENCY==1`; otherwise go to WAIT with `cnt = LATENCY-2`.
- WAIT: decrement `cnt` each cycle; go to RESP when `cnt==0`.
- RESP: `ready_out=1` for exactly one cycle, then return to IDLE unconditionally.
- Requests arriving in WAIT or RESP are ignored. The CPU holds its request stable until `ready_out` and drops it in the following cycle. A request still held in IDLE after RESP is treated as a new access.
- Illegal access, flagged by `error_out=1` in RESP:
  - `address_in[1:0]!=0`;
  - word index `address_in[31:2] >= DEPTH_WORDS`;
  - both controls high.
- On an illegal access the memory is not written and `data_out` is forced to 0.
- Legal store: the word at the captured index is written with the captured data. `data_out` = 0.
- Legal load: `data_out` = the word at the captured index.
- Memory contents are not initialised and are not cleared by reset.

## Timing
- A request present in IDLE during cycle C produces `ready_out` high in cycle C+LATENCY.
- The store commit and the `data_out` load happen on the edge ending cycle C+LATENCY-1.
- Minimum spacing between accepted requests is LATENCY+1 cycles.
- Reset values: state IDLE, `cnt` 0, `ready_out` 0, `error_out` 0, `data_out` 0.
- Reset in any state forces IDLE on the next edge. A pending store that has not yet committed is discarded. No `ready_out` is produced for the aborted access.
- Reset and a request in the same cycle: reset wins and the request is not captured.
- A load from a word stored by the immediately preceding access returns the new data.

## Configuration
- `DMEM_STATS_EN` defined:
  - Adds `rdCount_out[15:0]` and `wrCount_out[15:0]` outputs.
  - Each counter increments on RESP of a legal load or store respectively, and saturates at 16'hFFFF.
  - Both counters are cleared by reset.
- `DMEM_STATS_EN` not defined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `mips_mem_pkg`:
  - state enum `dmem_state_t` (IDLE/WAIT/RESP);
  - `DMEM_CNT_W = 4`;
  - access-kind constants.
- Sub-module `mem_word_array`: synchronous single-port word RAM with write-enable, index, write data, and registered read data. The FSM, counter, and error logic stay in `dmem_responder`.

## Test plan
- LATENCY=2, store 0xDEADBEEF to 0x10 in cycle 0: `ready_out` in cycle 2, `error_out=0`. A load from 0x10 issued in cycle 4 returns 0xDEADBEEF with `ready_out` in cycle 6.
- Load from 0x12: `ready_out` with `error_out=1`, `data_out=0`. A later load from 0x10 still returns 0xDEADBEEF.
- DEPTH_WORDS=256, store to 0x400: error flagged, and word 0 is unchanged when read back.
- Both controls high: `error_out=1` and no write occurs.
- Reset asserted in the WAIT cycle of a store of 0x12345678 to 0x20: no `ready_out`, state returns to IDLE, and word 0x20 keeps its old value.
- LATENCY=1 with a request held for 3 cycles: `ready_out` in cycles 1 and 3. With `DMEM_STATS_EN` defined, two loads give `rdCount_out=2`.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM state type, wait counter width,
// access-kind encoding and the illegal-access predicate.
package mips_mem_pkg;

   localparam int unsigned DMEM_CNT_W = 4;

   typedef enum logic [1:0] {StIdle, StWait, StResp} dmem_state_t;

   // Access kind is packed as {write, read}.
   localparam logic [1:0] AccRead  = 2'b01;
   localparam logic [1:0] AccWrite = 2'b10;
   localparam logic [1:0] AccBoth  = 2'b11;

   // Misaligned, beyond the last word, or both controls asserted.
   function automatic logic addr_illegal(input logic [31:0]  addr,
                                         input logic [1:0]   kind,
                                         input int unsigned  idx_w);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr[1:0] != 2'b00);
      out_of_range = ((addr >> (idx_w + 2)) != 32'd0);
      return misaligned || out_of_range || (kind == AccBoth);
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Synchronous single-port word RAM with registered read data. A write cycle leaves the
// read register untouched; contents are never initialised or cleared.
module mem_word_array #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // One access per enabled edge: write the word, or latch it into the read register.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[idx] <= wdata;
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with programmable wait states, a one-cycle completion
// pulse and illegal-access reporting. Define DMEM_STATS_EN to add saturating load/store
// counters (rdCount_out / wrCount_out).
module dmem_responder
   import mips_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        readCntrl_in,
   input  logic        writeCntrl_in,
   input  logic [31:0] address_in,
   input  logic [31:0] writeData_in,
   output logic [31:0] data_out,
   output logic        ready_out,
   output logic        error_out
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0] rdCount_out,
   output logic [15:0] wrCount_out
`endif
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [DMEM_CNT_W-1:0] CNT_LOAD =
      DMEM_CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

   dmem_state_t           state_q, state_d;
   logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]           addr_q, wdata_q;
   logic [1:0]            kind_q;

   logic        req;
   logic [1:0]  req_kind;
   logic [31:0] acc_addr, acc_wdata;
   logic [1:0]  acc_kind;
   logic        acc_err, resp_err, commit;
   logic [31:0] ram_rdata;

   assign req      = readCntrl_in | writeCntrl_in;
   assign req_kind = {writeCntrl_in, readCntrl_in};

   // With LATENCY==1 the RAM access shares its edge with the capture, so it must see the
   // live request; otherwise it uses the captured copy.
   assign acc_addr  = (state_q == StIdle) ? address_in   : addr_q;
   assign acc_wdata = (state_q == StIdle) ? writeData_in : wdata_q;
   assign acc_kind  = (state_q == StIdle) ? req_kind     : kind_q;
   assign acc_err   = addr_illegal(acc_addr, acc_kind, IDX_W);
   assign resp_err  = addr_illegal(addr_q, kind_q, IDX_W);

   // The edge entering RESP commits the store or fetches the load; reset cancels it.
   assign commit = (state_d == StResp) && !reset;

   mem_word_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_mem (
      .clk   (clk),
      .en    (commit && !acc_err),
      .we    (acc_kind == AccWrite),
      .idx   (acc_addr[IDX_W+1:2]),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   // State and wait-counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and counter logic; requests outside IDLE are ignored.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               if (LATENCY == 1) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Capture the accepted request so the CPU-side inputs may change afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         kind_q  <= '0;
      end else if ((state_q == StIdle) && req) begin
         addr_q  <= address_in;
         wdata_q <= writeData_in;
         kind_q  <= req_kind;
      end
   end

   // Response outputs, decoded from the RESP state and the captured access.
   always_comb begin
      ready_out = (state_q == StResp);
      error_out = ready_out && resp_err;
      data_out  = '0;
      if (ready_out && !resp_err && (kind_q == AccRead)) begin
         data_out = ram_rdata;
      end
   end

`ifdef DMEM_STATS_EN
   // Saturating counters of legal loads and stores, counted at their response.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdCount_out <= '0;
         wrCount_out <= '0;
      end else if (ready_out && !resp_err) begin
         if ((kind_q == AccRead) && (rdCount_out != 16'hFFFF)) begin
            rdCount_out <= rdCount_out + 16'd1;
         end
         if ((kind_q == AccWrite) && (wrCount_out != 16'hFFFF)) begin
            wrCount_out <= wrCount_out + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a vector table, hand sequences for reset and
// LATENCY==1 corner cases, and random traffic checked against a word-array model.
// Stats checks are compiled in when DMEM_STATS_EN is defined.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rd_a, wr_a, ready_a, error_a;
   logic [31:0] addr_a, wdata_a, data_a;
   logic        rst_b, rd_b, wr_b, ready_b, error_b;
   logic [31:0] addr_b, wdata_b, data_b;
`ifdef DMEM_STATS_EN
   logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;
`endif

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
      .clk           (clk),
      .reset         (rst_a),
      .readCntrl_in  (rd_a),
      .writeCntrl_in (wr_a),
      .address_in    (addr_a),
      .writeData_in  (wdata_a),
      .data_out      (data_a),
      .ready_out     (ready_a),
      .error_out     (error_a)
`ifdef DMEM_STATS_EN
      ,
      .rdCount_out   (rdc_a),
      .wrCount_out   (wrc_a)
`endif
   );

   dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut_b (
      .clk           (clk),
      .reset         (rst_b),
      .readCntrl_in  (rd_b),
      .writeCntrl_in (wr_b),
      .address_in    (addr_b),
      .writeData_in  (wdata_b),
      .data_out      (data_b),
      .ready_out     (ready_b),
      .error_out     (error_b)
`ifdef DMEM_STATS_EN
      ,
      .rdCount_out   (rdc_b),
      .wrCount_out   (wrc_b)
`endif
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_data;
   } vec_t;

   vec_t        vecs[11];
   logic [31:0] model_mem[8];
   int          checks = 0;
   int          errors = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   // One access on dut_a: hold until ready, check latency/flags/data, drop, check pulse end.
   task automatic txn_a(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_data, input string name);
      int k;
      @(posedge clk); #1;
      rd_a = rd; wr_a = wr; addr_a = addr; wdata_a = wdata;
      k = 0;
      @(negedge clk);
      while (!ready_a && k < 20) begin
         @(negedge clk);
         k++;
      end
      check32({name, " latency"}, 32'(k), 32'd2);
      check32({name, " error"}, {31'd0, error_a}, {31'd0, exp_err});
      check32({name, " data"}, data_a, exp_data);
      @(posedge clk); #1;
      rd_a = 1'b0; wr_a = 1'b0;
      @(negedge clk);
      check32({name, " pulse_end"}, {31'd0, ready_a}, 32'd0);
      if (!exp_err && rd) rd_cnt++;
      if (!exp_err && wr) wr_cnt++;
   endtask

   // Expected result derived from the access rules and the word-array model.
   task automatic model_op(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input string name);
      logic        err;
      logic [31:0] exp;
      int          idx;
      err = ((addr % 4) != 0) || ((addr / 4) >= 256) || (rd && wr);
      idx = int'(addr / 4);
      exp = 32'd0;
      if (!err && rd && idx < 8) exp = model_mem[idx];
      txn_a(rd, wr, addr, wdata, err, exp, name);
      if (!err && wr && idx < 8) model_mem[idx] = wdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 1'b0, 32'h12,  32'h0,        1'b1, 32'h0};
      vecs[3]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
      vecs[4]  = '{1'b0, 1'b1, 32'h00,  32'hA5A5A5A5, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, 1'b1, 32'h400, 32'h11111111, 1'b1, 32'h0};
      vecs[6]  = '{1'b1, 1'b0, 32'h00,  32'h0,        1'b0, 32'hA5A5A5A5};
      vecs[7]  = '{1'b1, 1'b1, 32'h10,  32'h0BADF00D, 1'b1, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
      vecs[9]  = '{1'b0, 1'b1, 32'h20,  32'hCAFEF00D, 1'b0, 32'h0};
      vecs[10] = '{1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 32'hCAFEF00D};

      rst_a = 1'b1; rd_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
      rst_b = 1'b1; rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check32("reset ready", {31'd0, ready_a}, 32'd0);
      check32("reset error", {31'd0, error_a}, 32'd0);
      check32("reset data", data_a, 32'd0);
      @(posedge clk); #1;
      rst_a = 1'b0; rst_b = 1'b0;

      for (int i = 0; i < 11; i++) begin
         txn_a(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err,
               vecs[i].exp_data, $sformatf("vec%0d", i));
      end

      // Reset lands on the WAIT cycle of a store, i.e. on its commit edge.
      @(posedge clk); #1;
      wr_a = 1'b1; addr_a = 32'h20; wdata_a = 32'h12345678;
      @(negedge clk);
      check32("abort cycle0 ready", {31'd0, ready_a}, 32'd0);
      @(posedge clk); #1;
      rst_a = 1'b1; wr_a = 1'b0;
      @(negedge clk);
      check32("abort wait ready", {31'd0, ready_a}, 32'd0);
      @(posedge clk); #1;
      rst_a = 1'b0;
      rd_cnt = 0; wr_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check32($sformatf("abort after%0d ready", i), {31'd0, ready_a}, 32'd0);
      end
      txn_a(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, "abort readback");

      // Reset and request together: the request must not be captured.
      @(posedge clk); #1;
      rst_a = 1'b1; rd_a = 1'b1; addr_a = 32'h10;
      @(posedge clk); #1;
      rst_a = 1'b0; rd_a = 1'b0;
      rd_cnt = 0; wr_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check32($sformatf("rst_req%0d ready", i), {31'd0, ready_a}, 32'd0);
      end

      // Random traffic against the model; first give the modelled words known contents.
      for (int i = 0; i < 8; i++) begin
         model_op(1'b0, 1'b1, 32'(i * 4), $urandom, $sformatf("init%0d", i));
      end
      for (int n = 0; n < 60; n++) begin
         int          kind_sel, addr_sel;
         logic        rd, wr;
         logic [31:0] addr;
         kind_sel = $urandom_range(0, 9);
         addr_sel = $urandom_range(0, 9);
         rd = (kind_sel <= 3) || (kind_sel >= 8);
         wr = (kind_sel >= 4);
         if (addr_sel <= 6)      addr = 32'($urandom_range(0, 7) * 4);
         else if (addr_sel == 7) addr = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
         else if (addr_sel == 8) addr = ($urandom | 32'h400) & 32'hFFFF_FFFC;
         else                    addr = 32'hFFFF_FFFC;
         model_op(rd, wr, addr, $urandom, $sformatf("rnd%0d", n));
      end

`ifdef DMEM_STATS_EN
      check32("stats rd_a", {16'd0, rdc_a}, 32'(rd_cnt));
      check32("stats wr_a", {16'd0, wrc_a}, 32'(wr_cnt));
`endif

      // LATENCY==1: store, then a read held for three cycles is serviced twice.
      @(posedge clk); #1;
      wr_b = 1'b1; addr_b = 32'h4; wdata_b = 32'h77;
      @(negedge clk);
      check32("l1 store c0 ready", {31'd0, ready_b}, 32'd0);
      @(negedge clk);
      check32("l1 store c1 ready", {31'd0, ready_b}, 32'd1);
      check32("l1 store c1 error", {31'd0, error_b}, 32'd0);
      @(posedge clk); #1;
      wr_b = 1'b0;
      @(posedge clk); #1;
      rd_b = 1'b1; addr_b = 32'h4;
      for (int k = 0; k < 5; k++) begin
         logic exp_rdy;
         exp_rdy = (k == 1) || (k == 3);
         @(negedge clk);
         check32($sformatf("l1 hold c%0d ready", k), {31'd0, ready_b}, {31'd0, exp_rdy});
         check32($sformatf("l1 hold c%0d data", k), data_b, exp_rdy ? 32'h77 : 32'h0);
         if (k == 2) begin
            @(posedge clk); #1;
            rd_b = 1'b0;
         end
      end
      txn_b_oor: begin
         @(posedge clk); #1;
         rd_b = 1'b1; addr_b = 32'h40;
         @(negedge clk);
         @(negedge clk);
         check32("l1 oor ready", {31'd0, ready_b}, 32'd1);
         check32("l1 oor error", {31'd0, error_b}, 32'd1);
         @(posedge clk); #1;
         rd_b = 1'b0;
      end
`ifdef DMEM_STATS_EN
      check32("stats rd_b", {16'd0, rdc_b}, 32'd2);
      check32("stats wr_b", {16'd0, wrc_b}, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
